turn_on_sequencer: RTL and testbench

TURN_ON_SEQUENCER -- requirements
Module: turn_on_sequencer

---
 rtl/turn_on_sequencer_if.sv | 26 ++
 rtl/turn_on_sequencer.sv | 110 +++++++++++
 tb/tb_turn_on_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/turn_on_sequencer_if.sv
// Signal bundle between the drum timing / power switch side and the turn-on sequencer.
// The master drives drum timing and switches; the slave (the sequencer) drives the power controls.
interface turn_on_sequencer_if;
    logic       DRUM_INDEX;
    logic       T0;
    logic       PWR_SW;
    logic       MP_RESTART;
    logic       PWR_CLEAR;
    logic       PWR_NO_CLEAR;
    logic       PWR_NT;
    logic       PWR_NO_OP;
    logic       PWR_OP;
    logic       PWR_DC_ON;
    logic       PWR_FAULT;
    logic [2:0] PWR_STATE;

    modport master (
        output DRUM_INDEX, T0, PWR_SW, MP_RESTART,
        input  PWR_CLEAR, PWR_NO_CLEAR, PWR_NT, PWR_NO_OP, PWR_OP, PWR_DC_ON, PWR_FAULT, PWR_STATE
    );

    modport slave (
        input  DRUM_INDEX, T0, PWR_SW, MP_RESTART,
        output PWR_CLEAR, PWR_NO_CLEAR, PWR_NT, PWR_NO_OP, PWR_OP, PWR_DC_ON, PWR_FAULT, PWR_STATE
    );
endinterface

// File: rtl/turn_on_sequencer.sv
// Power turn-on sequencer: heats for a number of drum revolutions, then steps the machine
// through CLEAR, NT, NO-OP and a one-word OP pulse into RUN, with a drum-index watchdog.
module turn_on_sequencer #(
    parameter int HEAT_REVS  = 4,
    parameter int REV_CYCLES = 3132
) (
    input  logic               CLOCK,
    input  logic               rst,
    turn_on_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        OFF   = 3'd0,
        HEAT  = 3'd1,
        CLEAR = 3'd2,
        NT    = 3'd3,
        NOOP  = 3'd4,
        OP    = 3'd5,
        RUN   = 3'd6
    } state_t;

    // A zero heat count still spends one revolution heating.
    localparam logic [7:0]  HEAT_TARGET = (HEAT_REVS == 0) ? 8'd1 : 8'(HEAT_REVS);
    localparam logic [12:0] WDOG_LAST   = 13'(2 * REV_CYCLES - 1);

    state_t      state, state_nxt;
    logic [7:0]  rev_cnt, rev_cnt_nxt;
    logic [12:0] wdog, wdog_nxt;
    logic        fault, fault_nxt;
    logic        restart_pend, restart_pend_nxt;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state        <= OFF;
            rev_cnt      <= '0;
            wdog         <= '0;
            fault        <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            state        <= state_nxt;
            rev_cnt      <= rev_cnt_nxt;
            wdog         <= wdog_nxt;
            fault        <= fault_nxt;
            restart_pend <= restart_pend_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        rev_cnt_nxt      = rev_cnt;
        fault_nxt        = fault;
        restart_pend_nxt = restart_pend;

        if (state == OFF || bus.DRUM_INDEX)
            wdog_nxt = '0;
        else
            wdog_nxt = wdog + 13'd1;

        case (state)
            OFF: begin
                if (bus.PWR_SW && !fault) begin
                    state_nxt   = HEAT;
                    rev_cnt_nxt = '0;
                end
            end
            HEAT: begin
                if (bus.DRUM_INDEX) begin
                    rev_cnt_nxt = rev_cnt + 8'd1;
                    if (rev_cnt + 8'd1 == HEAT_TARGET)
                        state_nxt = CLEAR;
                end
            end
            CLEAR: if (bus.DRUM_INDEX) state_nxt = NT;
            NT:    if (bus.DRUM_INDEX) state_nxt = NOOP;
            NOOP:  if (bus.DRUM_INDEX) state_nxt = OP;
            // The T0 that coincides with the entering index was sampled in NOOP, so it never counts here.
            OP:    if (bus.T0) state_nxt = RUN;
            RUN: begin
                if (bus.MP_RESTART)
                    restart_pend_nxt = 1'b1;
                if (bus.DRUM_INDEX && (restart_pend || bus.MP_RESTART))
                    state_nxt = CLEAR;
            end
            default: state_nxt = OFF;
        endcase

        if (state != OFF && !bus.DRUM_INDEX && wdog == WDOG_LAST) begin
            fault_nxt = 1'b1;
            state_nxt = OFF;
            wdog_nxt  = '0;
        end

        // Switch-off overrides everything and is the only way to clear a latched fault.
        if (!bus.PWR_SW) begin
            state_nxt = OFF;
            fault_nxt = 1'b0;
        end

        if (state_nxt != RUN)
            restart_pend_nxt = 1'b0;
    end

    assign bus.PWR_CLEAR    = (state == CLEAR);
    assign bus.PWR_NT       = (state == NT);
    assign bus.PWR_NO_OP    = (state == NOOP);
    assign bus.PWR_OP       = (state == OP);
    assign bus.PWR_NO_CLEAR = state inside {NT, NOOP, OP, RUN};
    assign bus.PWR_DC_ON    = state inside {CLEAR, NT, NOOP, OP, RUN};
    assign bus.PWR_FAULT    = fault;
    assign bus.PWR_STATE    = state;
endmodule

// File: tb/tb_turn_on_sequencer.sv
// Directed bench for turn_on_sequencer: main unit with HEAT_REVS=2, second unit with
// HEAT_REVS=0 sharing the drum timing and switch inputs but with its own reset.
module tb_turn_on_sequencer;
    localparam int REV = 3132;

    // {CLEAR, NO_CLEAR, NT, NO_OP, OP, DC_ON, FAULT, STATE[2:0]}
    localparam logic [31:0] O_OFF   = 32'b0_0_0_0_0_0_0_000;
    localparam logic [31:0] O_HEAT  = 32'b0_0_0_0_0_0_0_001;
    localparam logic [31:0] O_CLEAR = 32'b1_0_0_0_0_1_0_010;
    localparam logic [31:0] O_NT    = 32'b0_1_1_0_0_1_0_011;
    localparam logic [31:0] O_NOOP  = 32'b0_1_0_1_0_1_0_100;
    localparam logic [31:0] O_OP    = 32'b0_1_0_0_1_1_0_101;
    localparam logic [31:0] O_RUN   = 32'b0_1_0_0_0_1_0_110;
    localparam logic [31:0] O_FLT   = 32'b0_0_0_0_0_0_1_000;

    localparam logic [2:0] S_HEAT  = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_NT    = 3'd3;
    localparam logic [2:0] S_NOOP  = 3'd4;
    localparam logic [2:0] S_OP    = 3'd5;
    localparam logic [2:0] S_RUN   = 3'd6;

    logic CLOCK;
    logic rst;
    logic rst2;
    int   pos;
    bit   idx_on;
    int   n;
    int   n_pass;
    int   n_fail;
    int   n_total;

    turn_on_sequencer_if bus ();
    turn_on_sequencer_if bus2 ();

    assign bus2.DRUM_INDEX = bus.DRUM_INDEX;
    assign bus2.T0         = bus.T0;
    assign bus2.PWR_SW     = bus.PWR_SW;
    assign bus2.MP_RESTART = bus.MP_RESTART;

    turn_on_sequencer #(.HEAT_REVS(2), .REV_CYCLES(REV)) dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .bus   (bus)
    );

    turn_on_sequencer #(.HEAT_REVS(0), .REV_CYCLES(REV)) dut0 (
        .CLOCK (CLOCK),
        .rst   (rst2),
        .bus   (bus2)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    function automatic logic [31:0] outs(input int sel);
        if (sel == 0)
            return {22'd0, bus.PWR_CLEAR, bus.PWR_NO_CLEAR, bus.PWR_NT, bus.PWR_NO_OP,
                    bus.PWR_OP, bus.PWR_DC_ON, bus.PWR_FAULT, bus.PWR_STATE};
        return {22'd0, bus2.PWR_CLEAR, bus2.PWR_NO_CLEAR, bus2.PWR_NT, bus2.PWR_NO_OP,
                bus2.PWR_OP, bus2.PWR_DC_ON, bus2.PWR_FAULT, bus2.PWR_STATE};
    endfunction

    function automatic logic [2:0] get_state(input int sel);
        return (sel == 0) ? bus.PWR_STATE : bus2.PWR_STATE;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive drum timing for one clock and sample 1 time unit after the edge.
    task automatic step();
        bus.DRUM_INDEX = idx_on && (pos == 0);
        bus.T0         = (pos % 29 == 0);
        @(posedge CLOCK);
        #1;
        pos = (pos + 1) % REV;
    endtask

    // Count observed cycles spent in state st, bounded so a stuck state still ends.
    task automatic wait_leave(input int sel, input logic [2:0] st, output int cnt);
        cnt = 0;
        while (get_state(sel) == st && cnt < 4 * REV) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        rst = 1'b1; rst2 = 1'b1;
        idx_on = 1'b1;
        pos = REV - 4;
        bus.DRUM_INDEX = 1'b0; bus.T0 = 1'b0; bus.PWR_SW = 1'b0; bus.MP_RESTART = 1'b0;

        #2;
        check("reset_outs", outs(0), O_OFF);
        check("reset_outs0", outs(1), O_OFF);
        repeat (3) step();
        rst = 1'b0; rst2 = 1'b0;
        step();
        check("off_after_rst", outs(0), O_OFF);

        // Power on aligned with an index: that index must not count toward heating.
        bus.PWR_SW = 1'b1;
        step();
        check("heat_entry", outs(0), O_HEAT);
        check("heat_entry0", outs(1), O_HEAT);
        wait_leave(1, S_HEAT, n);
        check("heat0_len", 32'(n), 32'(REV));
        check("heat0_clear", outs(1), O_CLEAR);
        check("heat2_mid", outs(0), O_HEAT);
        wait_leave(0, S_HEAT, n);
        check("heat_len_rest", 32'(n), 32'(REV));
        check("clear_outs", outs(0), O_CLEAR);
        wait_leave(0, S_CLEAR, n);
        check("clear_len", 32'(n), 32'(REV));
        check("nt_outs", outs(0), O_NT);
        wait_leave(0, S_NT, n);
        check("nt_len", 32'(n), 32'(REV));
        check("noop_outs", outs(0), O_NOOP);

        // Second unit is one revolution ahead and sits in OP; reset it between clock edges.
        check("dut0_op", outs(1), O_OP);
        repeat (5) step();
        check("dut0_op_mid", outs(1), O_OP);
        #3;
        rst2 = 1'b1;
        #1;
        check("async_rst_op", outs(1), O_OFF);

        wait_leave(0, S_NOOP, n);
        check("noop_len", 32'(n), 32'(REV - 5));
        check("op_outs", outs(0), O_OP);
        check("dut0_rst_held", outs(1), O_OFF);
        wait_leave(0, S_OP, n);
        check("op_len", 32'(n), 32'd29);
        check("run_outs", outs(0), O_RUN);

        // Maintenance restart: one-cycle request waits for the next index, skips HEAT.
        bus.MP_RESTART = 1'b1;
        step();
        bus.MP_RESTART = 1'b0;
        check("restart_wait", outs(0), O_RUN);
        wait_leave(0, S_RUN, n);
        check("restart_delay", 32'(n), 32'(REV - 30));
        check("restart_clear", outs(0), O_CLEAR);
        wait_leave(0, S_CLEAR, n);
        check("rs_clear_len", 32'(n), 32'(REV));
        check("rs_nt", outs(0), O_NT);
        repeat (10) step();
        bus.MP_RESTART = 1'b1;
        step();
        bus.MP_RESTART = 1'b0;
        wait_leave(0, S_NT, n);
        check("rs_nt_len", 32'(n), 32'(REV - 11));
        check("restart_ignored", outs(0), O_NOOP);
        wait_leave(0, S_NOOP, n);
        check("rs_noop_len", 32'(n), 32'(REV));
        check("rs_op", outs(0), O_OP);
        wait_leave(0, S_OP, n);
        check("rs_op_len", 32'(n), 32'd29);
        check("rs_run", outs(0), O_RUN);

        // Switch dropped in NT exactly on an index: OFF wins over NT->NOOP.
        bus.MP_RESTART = 1'b1;
        step();
        bus.MP_RESTART = 1'b0;
        wait_leave(0, S_RUN, n);
        check("rs2_clear", outs(0), O_CLEAR);
        wait_leave(0, S_CLEAR, n);
        check("rs2_nt", outs(0), O_NT);
        while (pos != 0) step();
        check("nt_before_drop", outs(0), O_NT);
        bus.PWR_SW = 1'b0;
        step();
        check("drop_off", outs(0), O_OFF);
        repeat (3) step();
        check("drop_hold", outs(0), O_OFF);
        bus.PWR_SW = 1'b1;
        step();
        check("reheat_entry", outs(0), O_HEAT);
        wait_leave(0, S_HEAT, n);
        check("reheat_len", 32'(n), 32'(2 * REV - 4));
        check("reheat_clear", outs(0), O_CLEAR);

        // Index lost in NOOP: fault exactly 2*REV cycles after the last index.
        wait_leave(0, S_CLEAR, n);
        wait_leave(0, S_NT, n);
        check("wd_noop", outs(0), O_NOOP);
        idx_on = 1'b0;
        repeat (2 * REV - 1) step();
        check("wd_edge", outs(0), O_NOOP);
        step();
        check("wd_fault", outs(0), O_FLT);
        repeat (50) step();
        check("fault_hold", outs(0), O_FLT);
        bus.PWR_SW = 1'b0;
        step();
        check("fault_clear", outs(0), O_OFF);
        bus.PWR_SW = 1'b1;
        idx_on = 1'b1;
        step();
        check("heat_after_fault", outs(0), O_HEAT);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
